// File: rtl/ahb_master_mux.sv
// AHB master-to-slave multiplexor with data-phase master tracking and HTRANS sequence checking.
// Optional per-master transfer counters (XFER_CNT) are enabled by defining MUX_STATS_EN.
module ahb_master_mux #(
  parameter int unsigned NUM_MASTERS = 16,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  localparam int unsigned MW         = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic [MW-1:0]                 HMASTER,
  input  logic                          HMASTLOCK,
  input  logic                          HREADY,
  input  logic [NUM_MASTERS*ADDR_W-1:0] HADDRx,
  input  logic [NUM_MASTERS*2-1:0]      HTRANSx,
  input  logic [NUM_MASTERS-1:0]        HWRITEx,
  input  logic [NUM_MASTERS*3-1:0]      HSIZEx,
  input  logic [NUM_MASTERS*3-1:0]      HBURSTx,
  input  logic [NUM_MASTERS*DATA_W-1:0] HWDATAx,
  output logic [ADDR_W-1:0]             HADDR,
  output logic [1:0]                    HTRANS,
  output logic                          HWRITE,
  output logic [2:0]                    HSIZE,
  output logic [2:0]                    HBURST,
  output logic [DATA_W-1:0]             HWDATA,
  output logic [MW-1:0]                 HMASTER_D,
  output logic                          HMASTLOCK_D,
  output logic                          PROT_ERR
`ifdef MUX_STATS_EN
 ,output logic [NUM_MASTERS*16-1:0]     XFER_CNT
`endif
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  typedef enum logic {IDLE_S, BURST_S} state_t;

  state_t state, state_nxt, state_eff;
  logic   err_nxt;
  logic   dv;
  logic   active;

  // Address/control mux; unmatched (out-of-range) masters and reset yield IDLE/zero
  always_comb begin
    HADDR  = '0;
    HTRANS = TR_IDLE;
    HWRITE = 1'b0;
    HSIZE  = 3'b000;
    HBURST = 3'b000;
    if (!HRESET) begin
      for (int i = 0; i < int'(NUM_MASTERS); i++) begin
        if (HMASTER == MW'(i)) begin
          HADDR  = HADDRx[i*ADDR_W +: ADDR_W];
          HTRANS = HTRANSx[i*2 +: 2];
          HWRITE = HWRITEx[i];
          HSIZE  = HSIZEx[i*3 +: 3];
          HBURST = HBURSTx[i*3 +: 3];
        end
      end
    end
  end

  assign active = (HTRANS == TR_NONSEQ) || (HTRANS == TR_SEQ);

  // Write-data mux follows the data-phase owner, gated by the data-valid flag
  always_comb begin
    HWDATA = '0;
    if (dv) begin
      for (int i = 0; i < int'(NUM_MASTERS); i++) begin
        if (HMASTER_D == MW'(i)) HWDATA = HWDATAx[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      HMASTER_D   <= '0;
      HMASTLOCK_D <= 1'b0;
      dv          <= 1'b0;
    end else if (HREADY) begin
      HMASTER_D   <= HMASTER;
      HMASTLOCK_D <= HMASTLOCK;
      dv          <= active;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state    <= IDLE_S;
      PROT_ERR <= 1'b0;
    end else begin
      state    <= state_nxt;
      PROT_ERR <= err_nxt;
    end
  end

  // A new owner starts from IDLE_S, so its first beat must be NONSEQ
  always_comb begin
    state_nxt = state;
    state_eff = state;
    err_nxt   = 1'b0;
    if (HREADY) begin
      if (HMASTER != HMASTER_D) state_eff = IDLE_S;
      state_nxt = state_eff;
      case (state_eff)
        IDLE_S: begin
          if (HTRANS == TR_NONSEQ) state_nxt = BURST_S;
          else if (HTRANS == TR_SEQ || HTRANS == TR_BUSY) err_nxt = 1'b1;
        end
        BURST_S: begin
          if (HTRANS == TR_IDLE) state_nxt = IDLE_S;
        end
        default: state_nxt = IDLE_S;
      endcase
    end
  end

`ifdef MUX_STATS_EN
  logic [15:0] cnt [NUM_MASTERS];

  // Saturating count of accepted NONSEQ/SEQ beats per owning master
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int i = 0; i < int'(NUM_MASTERS); i++) cnt[i] <= '0;
    end else if (HREADY && active) begin
      for (int i = 0; i < int'(NUM_MASTERS); i++) begin
        if (HMASTER == MW'(i) && cnt[i] != 16'hFFFF) cnt[i] <= cnt[i] + 16'd1;
      end
    end
  end

  always_comb begin
    XFER_CNT = '0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) XFER_CNT[i*16 +: 16] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_ahb_master_mux.sv
// Directed self-checking bench for ahb_master_mux; a 12-master instance covers out-of-range HMASTER.
// Counter saturation is exercised when MUX_STATS_EN is defined.
module tb_ahb_master_mux;

  localparam int unsigned NM  = 16;
  localparam int unsigned NM2 = 12;

  logic            HCLK = 1'b0;
  logic            HRESET;
  logic [3:0]      hmaster;
  logic            hmastlock;
  logic            hready;
  logic [NM*32-1:0] haddrx;
  logic [NM*2-1:0]  htransx;
  logic [NM-1:0]    hwritex;
  logic [NM*3-1:0]  hsizex;
  logic [NM*3-1:0]  hburstx;
  logic [NM*32-1:0] hwdatax;

  logic [31:0] haddr, hwdata, haddr12, hwdata12;
  logic [1:0]  htrans, htrans12;
  logic        hwrite, hwrite12;
  logic [2:0]  hsize, hburst, hsize12, hburst12;
  logic [3:0]  hmaster_d, hmaster_d12;
  logic        hmastlock_d, hmastlock_d12, prot_err, prot_err12;
`ifdef MUX_STATS_EN
  logic [NM*16-1:0]  xfer_cnt;
  logic [NM2*16-1:0] xfer_cnt12;
  logic [NM*16-1:0]  cnt_exp;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 HCLK = ~HCLK;

  ahb_master_mux #(.NUM_MASTERS(NM)) u_dut (
    .HCLK(HCLK), .HRESET(HRESET), .HMASTER(hmaster), .HMASTLOCK(hmastlock), .HREADY(hready),
    .HADDRx(haddrx), .HTRANSx(htransx), .HWRITEx(hwritex), .HSIZEx(hsizex), .HBURSTx(hburstx),
    .HWDATAx(hwdatax), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize),
    .HBURST(hburst), .HWDATA(hwdata), .HMASTER_D(hmaster_d), .HMASTLOCK_D(hmastlock_d),
    .PROT_ERR(prot_err)
`ifdef MUX_STATS_EN
   ,.XFER_CNT(xfer_cnt)
`endif
  );

  ahb_master_mux #(.NUM_MASTERS(NM2)) u_dut12 (
    .HCLK(HCLK), .HRESET(HRESET), .HMASTER(hmaster), .HMASTLOCK(hmastlock), .HREADY(hready),
    .HADDRx(haddrx[NM2*32-1:0]), .HTRANSx(htransx[NM2*2-1:0]), .HWRITEx(hwritex[NM2-1:0]),
    .HSIZEx(hsizex[NM2*3-1:0]), .HBURSTx(hburstx[NM2*3-1:0]), .HWDATAx(hwdatax[NM2*32-1:0]),
    .HADDR(haddr12), .HTRANS(htrans12), .HWRITE(hwrite12), .HSIZE(hsize12), .HBURST(hburst12),
    .HWDATA(hwdata12), .HMASTER_D(hmaster_d12), .HMASTLOCK_D(hmastlock_d12), .PROT_ERR(prot_err12)
`ifdef MUX_STATS_EN
   ,.XFER_CNT(xfer_cnt12)
`endif
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_trans(input int m, input logic [1:0] t);
    htransx[m*2 +: 2] = t;
  endtask

  // Master i: addr A00000ii<<8, data D00000ii, write=i[0], size=i, burst=i+1; master 3 addr 1000
  task automatic init_masters();
    for (int i = 0; i < int'(NM); i++) begin
      haddrx[i*32 +: 32]  = 32'hA000_0000 | (32'(i) << 8);
      hwdatax[i*32 +: 32] = 32'hD000_0000 | 32'(i);
      hwritex[i]          = 1'(i);
      hsizex[i*3 +: 3]    = 3'(i);
      hburstx[i*3 +: 3]   = 3'(i + 1);
      htransx[i*2 +: 2]   = 2'b00;
    end
    haddrx[3*32 +: 32] = 32'h0000_1000;
  endtask

  initial begin
    // Reset held with random inputs
    HRESET    = 1'b1;
    hmaster   = 4'($urandom);
    hmastlock = 1'($urandom);
    hready    = 1'($urandom);
    for (int i = 0; i < int'(NM); i++) begin
      haddrx[i*32 +: 32]  = $urandom;
      hwdatax[i*32 +: 32] = $urandom;
      htransx[i*2 +: 2]   = 2'($urandom);
      hwritex[i]          = 1'($urandom);
      hsizex[i*3 +: 3]    = 3'($urandom);
      hburstx[i*3 +: 3]   = 3'($urandom);
    end
    repeat (3) @(negedge HCLK);
    #1;
    check("rst_htrans", 256'(htrans), 256'(2'b00));
    check("rst_haddr", 256'(haddr), 256'(0));
    check("rst_hwdata", 256'(hwdata), 256'(0));
    check("rst_hmaster_d", 256'(hmaster_d), 256'(0));
    check("rst_prot_err", 256'(prot_err), 256'(0));

    // SEQ from master 2 directly after reset
    @(negedge HCLK);
    init_masters();
    hmastlock = 1'b0;
    hready    = 1'b1;
    hmaster   = 4'd2;
    set_trans(2, 2'b11);
    HRESET    = 1'b0;
    #1;
    check("seq_htrans", 256'(htrans), 256'(2'b11));
    check("seq_err_pre", 256'(prot_err), 256'(0));
    @(negedge HCLK);
    check("seq_err_hi", 256'(prot_err), 256'(1));
    check("seq_hmaster_d", 256'(hmaster_d), 256'(2));
    set_trans(2, 2'b00);
    @(negedge HCLK);
    check("seq_err_lo", 256'(prot_err), 256'(0));

    // Master 3 NONSEQ address phase
    hmaster = 4'd3;
    set_trans(3, 2'b10);
    #1;
    check("m3_haddr", 256'(haddr), 256'(32'h1000));
    check("m3_htrans", 256'(htrans), 256'(2'b10));
    check("m3_hwrite", 256'(hwrite), 256'(1));
    check("m3_hsize", 256'(hsize), 256'(3));
    check("m3_hburst", 256'(hburst), 256'(4));
    @(negedge HCLK);
    check("m3_hmaster_d", 256'(hmaster_d), 256'(3));
    check("m3_hwdata", 256'(hwdata), 256'(32'hD000_0003));
    check("m3_err", 256'(prot_err), 256'(0));

    // Stall the data phase while ownership moves to master 5
    hready    = 1'b0;
    hmaster   = 4'd5;
    hmastlock = 1'b1;
    set_trans(3, 2'b00);
    set_trans(5, 2'b10);
    #1;
    check("m5_haddr_stall", 256'(haddr), 256'(32'hA000_0500));
    for (int k = 0; k < 2; k++) begin
      @(negedge HCLK);
      check("stall_hmaster_d", 256'(hmaster_d), 256'(3));
      check("stall_hwdata", 256'(hwdata), 256'(32'hD000_0003));
      check("stall_lock_d", 256'(hmastlock_d), 256'(0));
    end
    hready = 1'b1;
    @(negedge HCLK);
    check("m5_hmaster_d", 256'(hmaster_d), 256'(5));
    check("m5_lock_d", 256'(hmastlock_d), 256'(1));
    check("m5_hwdata", 256'(hwdata), 256'(32'hD000_0005));
    check("m5_err", 256'(prot_err), 256'(0));
    set_trans(5, 2'b11);
    @(negedge HCLK);
    check("m5_seq_err", 256'(prot_err), 256'(0));
    check("m5_seq_hwdata", 256'(hwdata), 256'(32'hD000_0005));
    set_trans(5, 2'b00);
    hmastlock = 1'b0;
    @(negedge HCLK);
    check("idle_hwdata", 256'(hwdata), 256'(0));
    set_trans(5, 2'b01);
    @(negedge HCLK);
    check("busy_err_hi", 256'(prot_err), 256'(1));
    set_trans(5, 2'b00);
    @(negedge HCLK);
    check("busy_err_lo", 256'(prot_err), 256'(0));

    // Master 13: in range for 16 masters, out of range for 12
    hmaster = 4'd13;
    set_trans(13, 2'b11);
    #1;
    check("oor_htrans12", 256'(htrans12), 256'(2'b00));
    check("oor_haddr12", 256'(haddr12), 256'(0));
    check("m13_haddr", 256'(haddr), 256'(32'hA000_0D00));
    check("m13_htrans", 256'(htrans), 256'(2'b11));
    @(negedge HCLK);
    check("m13_err", 256'(prot_err), 256'(1));
    check("oor_err12", 256'(prot_err12), 256'(0));
    check("oor_hwdata12", 256'(hwdata12), 256'(0));
    set_trans(13, 2'b00);

    // Reset mid data phase
    hmaster = 4'd3;
    set_trans(3, 2'b10);
    @(negedge HCLK);
    check("pre_rst_hwdata", 256'(hwdata), 256'(32'hD000_0003));
    HRESET = 1'b1;
    #1;
    check("mid_rst_hwdata", 256'(hwdata), 256'(0));
    check("mid_rst_hmaster_d", 256'(hmaster_d), 256'(0));
    check("mid_rst_htrans", 256'(htrans), 256'(2'b00));
    @(negedge HCLK);
    set_trans(3, 2'b00);
    hmaster = 4'd7;
    set_trans(7, 2'b10);
    HRESET = 1'b0;

`ifdef MUX_STATS_EN
    // Saturation of master 7 counter
    repeat (10) @(negedge HCLK);
    check("cnt7_10", 256'(xfer_cnt[7*16 +: 16]), 256'(16'd10));
    repeat (69990) @(negedge HCLK);
    cnt_exp = '0;
    cnt_exp[7*16 +: 16] = 16'hFFFF;
    check("cnt7_sat", 256'(xfer_cnt[7*16 +: 16]), 256'(16'hFFFF));
    check("cnt6_zero", 256'(xfer_cnt[6*16 +: 16]), 256'(0));
    check("cnt_all", 256'(xfer_cnt), 256'(cnt_exp));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
